// File: rtl/residual_energy_monitor_lag16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | residual_energy_monitor_lag16 : windowed residual/input energy, ERLE test  |
// | and hysteresis convergence flag. Option: RESIDUAL_MONITOR_PEAK_EN. Rev 1.0 |
// +----------------------------------------------------------------------------+
module residual_energy_monitor_lag16 #(
  parameter int WINDOW_LOG2  = 8,
  parameter int SAMPLE_PHASE = 2000,
  parameter int ERLE_SHIFT   = 4,
  parameter int CONV_COUNT   = 3
) (
  input  logic                      clk_operation,
  input  logic                      rst_n,
  input  logic [12:0]               sampling_cycle_counter,
  input  logic                      enable,
  input  logic signed [15:0]        sig16b_without_echo,
  input  logic signed [15:0]        sig16b,
  output logic                      window_done,
  output logic [32+WINDOW_LOG2-1:0] residual_energy,
  output logic [32+WINDOW_LOG2-1:0] input_energy,
  output logic                      window_pass,
  output logic                      converged,
  output logic [3:0]                pass_count
`ifdef RESIDUAL_MONITOR_PEAK_EN
  ,
  output logic [15:0]               residual_peak
`endif
);

  localparam int c_ACC_W = 32 + WINDOW_LOG2;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ACCUM = 2'd1;
  localparam logic [1:0] c_ST_EVAL  = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic                     w_capture;
  logic                     w_accumulate;
  logic                     w_eval;

  logic                     r_cap_valid;
  logic signed [15:0]       r_res_cap;
  logic signed [15:0]       r_in_cap;
  logic                     r_sq_valid;
  logic [31:0]              r_res_sq;
  logic [31:0]              r_in_sq;
  logic [c_ACC_W-1:0]       r_res_acc;
  logic [c_ACC_W-1:0]       r_in_acc;
  logic [WINDOW_LOG2-1:0]   r_sample_cnt;

  logic signed [31:0]       w_res_ext;
  logic signed [31:0]       w_in_ext;
  logic                     w_pass;
  logic [3:0]               w_cnt_inc;

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE:  w_state_nxt = c_ST_ACCUM;
        c_ST_ACCUM: if (r_sq_valid && (&r_sample_cnt)) w_state_nxt = c_ST_EVAL;
        c_ST_EVAL:  w_state_nxt = c_ST_ACCUM;
        default:    w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  // A strobe landing in EVAL is kept and counted toward the next window.
  always_comb begin
    w_capture    = 1'b0;
    w_accumulate = 1'b0;
    w_eval       = 1'b0;
    if (enable) begin
      w_capture    = (sampling_cycle_counter == 13'(SAMPLE_PHASE)) &&
                     (r_state == c_ST_ACCUM || r_state == c_ST_EVAL);
      w_accumulate = r_sq_valid && (r_state == c_ST_ACCUM);
      w_eval       = (r_state == c_ST_EVAL);
    end
  end

  assign w_res_ext = 32'(r_res_cap);
  assign w_in_ext  = 32'(r_in_cap);
  assign w_pass    = ({r_res_acc, {ERLE_SHIFT{1'b0}}} < {{ERLE_SHIFT{1'b0}}, r_in_acc});
  assign w_cnt_inc = (pass_count == 4'd15) ? 4'd15 : pass_count + 4'd1;

`ifdef RESIDUAL_MONITOR_PEAK_EN
  logic [15:0] w_res_abs;
  logic [15:0] r_res_abs;
  logic [15:0] r_peak_run;
  // |-32768| does not fit in 15 bits of magnitude, so it saturates.
  assign w_res_abs = (r_res_cap == 16'sh8000) ? 16'h7fff :
                     (r_res_cap[15] ? 16'(-r_res_cap) : 16'(r_res_cap));
`endif

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_valid     <= 1'b0;
      r_res_cap       <= '0;
      r_in_cap        <= '0;
      r_sq_valid      <= 1'b0;
      r_res_sq        <= '0;
      r_in_sq         <= '0;
      r_res_acc       <= '0;
      r_in_acc        <= '0;
      r_sample_cnt    <= '0;
      window_done     <= 1'b0;
      residual_energy <= '0;
      input_energy    <= '0;
      window_pass     <= 1'b0;
      converged       <= 1'b0;
      pass_count      <= '0;
`ifdef RESIDUAL_MONITOR_PEAK_EN
      r_res_abs       <= '0;
      r_peak_run      <= '0;
      residual_peak   <= '0;
`endif
    end else begin
      r_cap_valid <= w_capture;
      if (w_capture) begin
        r_res_cap <= sig16b_without_echo;
        r_in_cap  <= sig16b;
      end
      r_sq_valid <= r_cap_valid && enable;
      if (r_cap_valid) begin
        r_res_sq <= w_res_ext * w_res_ext;
        r_in_sq  <= w_in_ext * w_in_ext;
`ifdef RESIDUAL_MONITOR_PEAK_EN
        r_res_abs <= w_res_abs;
`endif
      end

      if (!enable || r_state == c_ST_IDLE) begin
        r_res_acc    <= '0;
        r_in_acc     <= '0;
        r_sample_cnt <= '0;
`ifdef RESIDUAL_MONITOR_PEAK_EN
        r_peak_run   <= '0;
`endif
      end else if (w_eval) begin
        r_res_acc    <= r_sq_valid ? {{WINDOW_LOG2{1'b0}}, r_res_sq} : '0;
        r_in_acc     <= r_sq_valid ? {{WINDOW_LOG2{1'b0}}, r_in_sq} : '0;
        r_sample_cnt <= r_sq_valid ? WINDOW_LOG2'(1) : '0;
`ifdef RESIDUAL_MONITOR_PEAK_EN
        r_peak_run   <= r_sq_valid ? r_res_abs : '0;
`endif
      end else if (w_accumulate) begin
        r_res_acc    <= r_res_acc + {{WINDOW_LOG2{1'b0}}, r_res_sq};
        r_in_acc     <= r_in_acc + {{WINDOW_LOG2{1'b0}}, r_in_sq};
        r_sample_cnt <= r_sample_cnt + WINDOW_LOG2'(1);
`ifdef RESIDUAL_MONITOR_PEAK_EN
        if (r_res_abs > r_peak_run) r_peak_run <= r_res_abs;
`endif
      end

      window_done <= w_eval;
      if (w_eval) begin
        residual_energy <= r_res_acc;
        input_energy    <= r_in_acc;
        window_pass     <= w_pass;
`ifdef RESIDUAL_MONITOR_PEAK_EN
        residual_peak   <= r_peak_run;
`endif
        if (w_pass) begin
          pass_count <= w_cnt_inc;
          converged  <= (w_cnt_inc >= 4'(CONV_COUNT));
        end else begin
          pass_count <= '0;
          converged  <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_residual_energy_monitor_lag16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_residual_energy_monitor_lag16 : scoreboard bench with reference model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_residual_energy_monitor_lag16;

  localparam int c_WL2    = 8;
  localparam int c_PHASE  = 3;
  localparam int c_PERIOD = 8;
  localparam int c_WIN    = 1 << c_WL2;

  logic               clk_operation = 1'b0;
  logic               rst_n = 1'b0;
  logic [12:0]        scc = '0;
  logic               enable = 1'b0;
  logic signed [15:0] res_s = '0;
  logic signed [15:0] in_s = '0;
  logic               window_done;
  logic [39:0]        residual_energy;
  logic [39:0]        input_energy;
  logic               window_pass;
  logic               converged;
  logic [3:0]         pass_count;
`ifdef RESIDUAL_MONITOR_PEAK_EN
  logic [15:0]        residual_peak;
`endif

  residual_energy_monitor_lag16 #(
    .WINDOW_LOG2(c_WL2), .SAMPLE_PHASE(c_PHASE), .ERLE_SHIFT(4), .CONV_COUNT(3)
  ) dut (
    .clk_operation(clk_operation),
    .rst_n(rst_n),
    .sampling_cycle_counter(scc),
    .enable(enable),
    .sig16b_without_echo(res_s),
    .sig16b(in_s),
    .window_done(window_done),
    .residual_energy(residual_energy),
    .input_energy(input_energy),
    .window_pass(window_pass),
    .converged(converged),
    .pass_count(pass_count)
`ifdef RESIDUAL_MONITOR_PEAK_EN
    ,
    .residual_peak(residual_peak)
`endif
  );

  always #5 clk_operation = ~clk_operation;

  longint cyc = 0;
  always @(posedge clk_operation) cyc <= cyc + 1;

  typedef struct {
    longint res_e;
    longint in_e;
    bit     pass;
    bit     conv;
    int     pc;
    int     peak;
    longint done_cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;

  // Reference model state: one window's running sums plus the hysteresis filter.
  longint m_res_sum = 0, m_in_sum = 0;
  int     m_n = 0, m_peak = 0, m_pc = 0;
  bit     m_conv = 0;
  int     cap_idx = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear_window();
    m_res_sum = 0; m_in_sum = 0; m_n = 0; m_peak = 0;
  endtask

  task automatic model_capture(input int r, input int x);
    exp_t e;
    int a;
    m_res_sum += longint'(r) * longint'(r);
    m_in_sum  += longint'(x) * longint'(x);
    a = (r < 0) ? -r : r;
    if (a > 32767) a = 32767;
    if (a > m_peak) m_peak = a;
    m_n++;
    if (m_n == c_WIN) begin
      e.res_e = m_res_sum;
      e.in_e  = m_in_sum;
      e.pass  = (m_res_sum * 16) < m_in_sum;
      if (e.pass) begin
        m_pc   = (m_pc < 15) ? m_pc + 1 : 15;
        m_conv = (m_pc >= 3);
      end else begin
        m_pc   = 0;
        m_conv = 0;
      end
      e.conv     = m_conv;
      e.pc       = m_pc;
      e.peak     = m_peak;
      e.done_cyc = cyc + 4;
      exp_q.push_back(e);
      model_clear_window();
    end
  endtask

  task automatic gen_sample(input int mode, output int r, output int x);
    case (mode)
      0: begin r = 100;  x = 1000; end
      1: begin r = 500;  x = 1000; end
      2: begin r = -32768; x = -32768; end
      3: begin r = 0;    x = 0; end
      4: begin r = int'($urandom_range(4000)) - 2000; x = int'($urandom_range(65535)) - 32768; end
      5: begin r = int'($urandom_range(65535)) - 32768; x = int'($urandom_range(65535)) - 32768; end
      6: begin r = (cap_idx % 2 == 0) ? 37 : -32768; x = 1000; end
      default: begin r = 1234; x = 1000; end
    endcase
  endtask

  // One clock of stimulus; returns 1 when a sample was presented to the strobe.
  task automatic step(input int mode, output bit captured);
    int r, x;
    @(negedge clk_operation);
    scc = 13'((int'(scc) + 1) % c_PERIOD);
    captured = 0;
    if (scc == 13'(c_PHASE) && enable && rst_n) begin
      gen_sample(mode, r, x);
      res_s = 16'(r);
      in_s  = 16'(x);
      model_capture(r, x);
      cap_idx++;
      captured = 1;
    end else begin
      res_s = 16'($urandom);
      in_s  = 16'($urandom);
    end
  endtask

  task automatic run_caps(input int mode, input int n);
    int done;
    bit c;
    done = 0;
    while (done < n) begin
      step(mode, c);
      if (c) done++;
    end
    while (scc != 0) step(mode, c);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"}, window_done, 0);
    chk({tag, "_res_e"}, residual_energy, 0);
    chk({tag, "_in_e"}, input_energy, 0);
    chk({tag, "_pass"}, window_pass, 0);
    chk({tag, "_conv"}, converged, 0);
    chk({tag, "_pcnt"}, pass_count, 0);
  endtask

  // Scoreboard monitor: pops one expectation per window_done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_operation);
      if (rst_n && window_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("residual_energy", residual_energy, e.res_e);
          chk("input_energy", input_energy, e.in_e);
          chk("window_pass", window_pass, e.pass);
          chk("converged", converged, e.conv);
          chk("pass_count", pass_count, e.pc);
`ifdef RESIDUAL_MONITOR_PEAK_EN
          chk("residual_peak", residual_peak, e.peak);
`endif
        end
      end
    end
  end

  initial begin
    bit c;
    for (int i = 0; i < 6; i++) begin
      step(5, c);
      enable = 1'($urandom);
      check_zero("reset");
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    while (scc != 0) step(0, c);
    enable = 1'b1;

    run_caps(0, 3 * c_WIN);
    run_caps(1, c_WIN);
    run_caps(0, 3 * c_WIN);

    run_caps(0, 100);
    enable = 1'b0;
    model_clear_window();
    for (int i = 0; i < 20; i++) step(0, c);
    while (scc != 0) step(0, c);
    chk("abort_hold_conv", converged, m_conv);
    chk("abort_hold_pcnt", pass_count, m_pc);
    enable = 1'b1;
    run_caps(0, c_WIN);

    run_caps(2, c_WIN);
    run_caps(3, c_WIN);
    run_caps(4, 2 * c_WIN);
    run_caps(5, c_WIN);
    cap_idx = 0;
    run_caps(6, c_WIN);
    run_caps(7, c_WIN);

    run_caps(5, 50);
    rst_n = 1'b0;
    model_clear_window();
    m_pc = 0;
    m_conv = 0;
    step(0, c);
    check_zero("midreset");
    rst_n = 1'b1;
    run_caps(0, 3 * c_WIN);

    for (int i = 0; i < 10; i++) step(0, c);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/residual_energy_monitor_lag16.md
# residual_energy_monitor_lag16

Downstream monitor for the lag-16 echo canceller. Once per sampling period it captures the canceller's residual output and the matching near-end input sample, and accumulates the energy of each over a fixed window. At the end of each window it compares the two energies against an echo-return-loss-enhancement (ERLE) threshold. It raises a hysteresis-filtered `converged` flag, which supervisory logic uses to freeze adaptation or to report status.

## Interface
- `WINDOW_LOG2`, 8, window length is 2^WINDOW_LOG2 samples (legal range 2..12).
- `SAMPLE_PHASE`, 2000, value of `sampling_cycle_counter` at which inputs are captured.
- `ERLE_SHIFT`, 4, pass condition is residual energy × 2^ERLE_SHIFT < input energy (4 corresponds to 12 dB).
- `CONV_COUNT`, 3, number of consecutive passing windows required to assert `converged`.
- `clk_operation`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sampling_cycle_counter`  in  13  free-running sample-phase counter.
- `enable`  in  1  monitoring enable; level-sensitive.
- `sig16b_without_echo`  in  16  signed residual from the canceller.
- `sig16b`  in  16  signed near-end input, aligned to the residual.
- `window_done`  out  1  one-cycle pulse when a window is evaluated.
- `residual_energy`  out  32+WINDOW_LOG2  latched residual energy of the last window.
- `input_energy`  out  32+WINDOW_LOG2  latched input energy of the last window.
- `window_pass`  out  1  ERLE result of the last window.
- `converged`  out  1  filtered convergence flag.
- `pass_count`  out  4  consecutive passing windows, saturating at 15.

## Operation
- FSM has three states: IDLE, ACCUM, EVAL.
- IDLE: accumulators and sample counter are held at 0. Enters ACCUM on the first clock with `enable`=1.
- ACCUM:
  - Capture strobe is (`sampling_cycle_counter`==SAMPLE_PHASE && `enable`).
  - Each capture registers both inputs. Next cycle, squares are formed: signed 16×16 giving an unsigned 32-bit result; (−32768)² = 2^30 fits.
  - The cycle after that, each square is added to its accumulator and the sample counter increments.
  - After the 2^WINDOW_LOG2-th accumulation, move to EVAL.
- EVAL (one cycle):
  - pass = ({residual_acc, ERLE_SHIFT zeros} < input_acc). The comparison is done at width 32+WINDOW_LOG2+ERLE_SHIFT, unsigned and strict.
  - Latch the energies, pass, and the hysteresis update; clear the accumulators and counter; return to ACCUM.
- Hysteresis:
  - pass: `pass_count` increments, saturating at 15. `converged` is set when the new count ≥ CONV_COUNT.
  - fail: `pass_count` is set to 0 and `converged` is cleared immediately.
- Accumulators cannot overflow: the worst case is 2^WINDOW_LOG2 × 2^30.
- `enable` falling in any state: the partial window is discarded, in-flight pipeline stages are flushed, and the FSM goes to IDLE. Latched outputs, `converged` and `pass_count` hold their values.
- Both energies zero: pass=0 because the comparison is strict.

## Timing
- Reset value of every output is 0. All FSM, pipeline and accumulator state is 0, and the FSM is in IDLE.
- Let T be the capture cycle of the last sample of a window:
  - T+1: square registered.
  - T+2: accumulated; FSM enters EVAL.
  - T+3: `window_done`=1, and `residual_energy`, `input_energy`, `window_pass`, `converged` and `pass_count` are updated in the same edge.
- Total latency from last capture to `window_done` is 3 cycles. The next window's first capture cannot occur before T+2500 with the default period, so there is no overlap.
- A capture strobe coinciding with EVAL cannot occur with a sampling period > 3 cycles. If it does occur, the sample is counted toward the new window.
- Reset asserted mid-window: everything clears asynchronously. After release the FSM is in IDLE.
- `enable` low on the same cycle as a capture strobe: no capture.

## Configuration
- `RESIDUAL_MONITOR_PEAK_EN`: adds the output `residual_peak` (16 bits, unsigned) holding the maximum |`sig16b_without_echo`| in the last window, latched at `window_done`.
  - |−32768| saturates to 32767.
  - Reset value is 0; the running peak clears with the accumulators.
- Without the macro, the port and its logic are absent and all other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0, no `window_done`.
- Converging: defaults; residual=100, input=1000 constant; `enable`=1.
  - Each window: `residual_energy`=2,560,000, `input_energy`=256,000,000, `window_pass`=1.
  - `converged` rises at the 3rd `window_done`, exactly 3 cycles after the 256th capture of that window.
- Failing: residual=500, input=1000 → `residual_energy`=64,000,000, `window_pass`=0, `pass_count`=0. If `converged` was set beforehand, it drops at that `window_done`.
- Extremes: residual=−32768, input=−32768 → both energies 2^38, pass=0. Residual=0, input=0 → pass=0.
- Abort: drop `enable` after 100 captures, re-enable → no `window_done` for the partial window; the next window reports exactly 256 samples' energy; `converged` and `pass_count` unchanged across the abort.
- Macro build: residual samples alternating between 37 and −32768 → `residual_peak`=32767. With a constant residual of 1234, `residual_peak`=1234.
